// File: rtl/lpm_pkg.sv
// Shared constants and helpers for the LPM multiplier family.
// Representation strings and the full-precision product width live here.
package lpm_pkg;

   localparam string REP_SIGNED   = "SIGNED";
   localparam string REP_UNSIGNED = "UNSIGNED";

   // One guard bit above a*b leaves room for the addend carry.
   function automatic int full_width(input int widtha, input int widthb);
      return widtha + widthb + 1;
   endfunction

endpackage

// File: rtl/lpm_mult_pipe_reg.sv
// Single pipeline stage: synchronous clear, hold while clken is high.
// Clear takes priority over hold.
module lpm_mult_pipe_reg #(
   parameter int width = 1
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             clken,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);

   always_ff @(posedge clock) begin
      if (aclr) begin
         q <= '0;
      end else if (!clken) begin
         q <= d;
      end
   end

endmodule

// File: rtl/lpm_mult.sv
// Multiply-add: result = dataa*datab + sum, truncated or extended to lpm_widthp.
// The full-precision product is registered first; later stages are plain delays.
module lpm_mult
   import lpm_pkg::*;
#(
   parameter int    lpm_widtha         = 16,
   parameter int    lpm_widthb         = 16,
   parameter int    lpm_widthp         = 16,
   parameter int    lpm_widths         = 1,
   parameter int    lpm_pipeline       = 0,
   parameter string lpm_representation = "UNSIGNED",
   parameter string lpm_hint           = "UNUSED",
   parameter string lpm_type           = "LPM_MULT"
) (
   input  logic                  clock,
   input  logic                  aclr,
   input  logic                  clken,
   input  logic [lpm_widtha-1:0] dataa,
   input  logic [lpm_widthb-1:0] datab,
   input  logic [lpm_widths-1:0] sum,
   output logic [lpm_widthp-1:0] result
);

   localparam int FW        = full_width(lpm_widtha, lpm_widthb);
   localparam int IW        = (lpm_widthp > FW) ? lpm_widthp : FW;
   localparam bit IS_SIGNED = (lpm_representation == REP_SIGNED);

   logic [IW-1:0] a_ext;
   logic [IW-1:0] b_ext;
   logic [IW-1:0] s_ext;
   logic [IW-1:0] prod;

   // Extending before multiplying makes the low IW bits exact in both representations.
   always_comb begin
      if (IS_SIGNED) begin
         a_ext = IW'($signed(dataa));
         b_ext = IW'($signed(datab));
         s_ext = IW'($signed(sum));
      end else begin
         a_ext = IW'(dataa);
         b_ext = IW'(datab);
         s_ext = IW'(sum);
      end
      prod = a_ext * b_ext + s_ext;
   end

   logic [lpm_pipeline:0][FW-1:0] stage;

   assign stage[0] = prod[FW-1:0];

   for (genvar i = 0; i < lpm_pipeline; i++) begin : g_stage
      lpm_mult_pipe_reg #(
         .width(FW)
      ) u_reg (
         .clock(clock),
         .aclr (aclr),
         .clken(clken),
         .d    (stage[i]),
         .q    (stage[i+1])
      );
   end

   if (lpm_widthp <= FW) begin : g_trunc
      assign result = stage[lpm_pipeline][lpm_widthp-1:0];
   end else begin : g_ext
      logic msb;
      assign msb    = IS_SIGNED ? stage[lpm_pipeline][FW-1] : 1'b0;
      assign result = {{(lpm_widthp-FW){msb}}, stage[lpm_pipeline]};
   end

   // Bits and controls that a given parameterisation leaves unread.
   logic unused_ok;
   assign unused_ok = ^{prod, stage, clock, aclr, clken, (lpm_hint == ""), (lpm_type == "")};

endmodule

// File: tb/tb_lpm_mult.sv
// Bench for lpm_mult: several parameterisations checked against an arithmetic model.
// Pipelined instances are compared on every falling edge; literals pin the model.
module tb_lpm_mult;

   logic clock;
   logic aclr1, aclr2;
   logic clken, clken2;

   logic [15:0] a1, b1;
   logic        s1;
   logic [15:0] a2, b2;
   logic        s2;
   logic [15:0] s0a, s0b, s0s;
   logic [15:0] c0a, c0b;
   logic        c0s;
   logic [3:0]  wa, wb, ws;
   logic        inc;
   logic [15:0] cnt_a;

   logic [15:0] r_u1, r_p2, r_s0, r_c0, r_cnt;
   logic [11:0] r_w;

   int n_cmp = 0;
   int n_err = 0;

   assign cnt_a = {1'b0, r_cnt[14:8], 7'b0, inc};

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUTs ----------------
   lpm_mult #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widthp(16), .lpm_widths(1),
              .lpm_pipeline(1), .lpm_representation("UNSIGNED")) d_u1 (
      .clock(clock), .aclr(aclr1), .clken(clken), .dataa(a1), .datab(b1), .sum(s1), .result(r_u1));

   lpm_mult #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widthp(16), .lpm_widths(1),
              .lpm_pipeline(2), .lpm_representation("UNSIGNED")) d_p2 (
      .clock(clock), .aclr(aclr2), .clken(clken2), .dataa(a2), .datab(b2), .sum(s2), .result(r_p2));

   lpm_mult #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widthp(16), .lpm_widths(16),
              .lpm_pipeline(0), .lpm_representation("SIGNED")) d_s0 (
      .clock(clock), .aclr(aclr1), .clken(clken), .dataa(s0a), .datab(s0b), .sum(s0s), .result(r_s0));

   lpm_mult #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widthp(16), .lpm_widths(1),
              .lpm_pipeline(0), .lpm_representation("UNSIGNED")) d_c0 (
      .clock(clock), .aclr(aclr1), .clken(clken), .dataa(c0a), .datab(c0b), .sum(c0s), .result(r_c0));

   lpm_mult #(.lpm_widtha(4), .lpm_widthb(4), .lpm_widthp(12), .lpm_widths(4),
              .lpm_pipeline(0), .lpm_representation("SIGNED")) d_w (
      .clock(clock), .aclr(aclr1), .clken(clken), .dataa(wa), .datab(wb), .sum(ws), .result(r_w));

   lpm_mult #(.lpm_widtha(16), .lpm_widthb(16), .lpm_widthp(16), .lpm_widths(1),
              .lpm_pipeline(1), .lpm_representation("SIGNED")) d_cnt (
      .clock(clock), .aclr(aclr1), .clken(clken), .dataa(cnt_a), .datab(16'h0101), .sum(1'b0), .result(r_cnt));

   // ---------------- model ----------------
   function automatic longint sx(input longint v, input int w, input bit sgn);
      longint m;
      m = v & ((longint'(1) << w) - 1);
      if (sgn && m[w-1]) m = m - (longint'(1) << w);
      return m;
   endfunction

   // Exact integer multiply-add, wrapped to the full product width, then fitted to wp.
   function automatic longint mref(input longint a, input longint b, input longint s, input bit sgn,
                                   input int wda, input int wdb, input int wds, input int wp);
      longint p;
      p = sx(sx(a, wda, sgn) * sx(b, wdb, sgn) + sx(s, wds, sgn), wda + wdb + 1, sgn);
      return sx(p, wp, 1'b0);
   endfunction

   longint m1;
   longint q2[$];
   int     cnt_m;
   bit     m1_ok = 0, m2_ok = 0, cnt_ok = 0;

   always @(posedge clock) begin
      if (aclr1) begin
         m1 = 0; m1_ok = 1;
         cnt_m = 0; cnt_ok = 1;
      end else begin
         m1 = mref(longint'(a1), longint'(b1), longint'(s1), 1'b0, 16, 16, 1, 16);
         cnt_m = (cnt_m + int'(inc)) % 128;
      end
      if (aclr2) begin
         q2 = '{0, 0}; m2_ok = 1;
      end else if (!clken2 && m2_ok) begin
         q2.push_front(mref(longint'(a2), longint'(b2), longint'(s2), 1'b0, 16, 16, 1, 16));
         void'(q2.pop_back());
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (m1_ok)  check("u1_model",  64'(r_u1), 64'(m1[15:0]));
      if (m2_ok)  check("p2_model",  64'(r_p2), 64'(q2[1][15:0]));
      if (cnt_ok) check("cnt_model", 64'(r_cnt[14:8]), 64'(cnt_m));
   end

   // ---------------- directed vectors ----------------
   localparam int NV = 5;
   logic [32:0] vec [NV] = '{
      {16'hFFFF, 16'hFFFF, 1'b1},
      {16'h1234, 16'h0010, 1'b1},
      {16'h0000, 16'hABCD, 1'b1},
      {16'h8000, 16'h0002, 1'b0},
      {16'h00FF, 16'h0101, 1'b0}
   };

   initial begin
      aclr1 = 1'b1; aclr2 = 1'b1; clken = 1'b0; clken2 = 1'b0;
      a1 = '0; b1 = '0; s1 = 1'b0; a2 = '0; b2 = '0; s2 = 1'b0; inc = 1'b0;

      // combinational instances, before any clock edge
      s0a = 16'hFFFE; s0b = 16'd3; s0s = 16'd0;
      c0a = 16'd7; c0b = 16'd6; c0s = 1'b1;
      wa = 4'h8; wb = 4'h7; ws = 4'h8;
      #1;
      check("s0_neg",   64'(r_s0), 64'h0000_FFFA);
      check("s0_neg_m", 64'(r_s0), 64'(mref(64'hFFFE, 3, 0, 1'b1, 16, 16, 16, 16)));
      check("c0_comb",  64'(r_c0), 64'd43);
      check("w_sext",   64'(r_w),  64'h0FC0);
      check("w_sext_m", 64'(r_w),  64'(mref(8, 7, 8, 1'b1, 4, 4, 4, 12)));
      s0a = 16'h0100; s0b = 16'h0100;
      wa = 4'h8; wb = 4'h8; ws = 4'h0;
      #1;
      check("s0_trunc", 64'(r_s0), 64'h0);
      check("w_pos",    64'(r_w),  64'h040);

      @(negedge clock);
      check("u1_reset",  64'(r_u1),  64'h0);
      check("p2_reset",  64'(r_p2),  64'h0);
      check("cnt_reset", 64'(r_cnt), 64'h0);
      aclr1 = 1'b0; aclr2 = 1'b0; inc = 1'b1;
      a1 = 16'd3; b1 = 16'd5; s1 = 1'b0;
      a2 = 16'h0042; b2 = 16'd1; s2 = 1'b0;

      for (int k = 1; k <= 140; k++) begin
         @(negedge clock);
         if (k == 1) check("u1_3x5", 64'(r_u1), 64'd15);
         if (k <= NV) {a1, b1, s1} = vec[k-1];
         if (k == 2) check("p2_first", 64'(r_p2), 64'h0042);
         if (k == 3) begin
            a2 = 16'd5; b2 = 16'd5; clken2 = 1'b1;
         end
         if (k >= 4 && k <= 6) check("p2_hold", 64'(r_p2), 64'h0042);
         if (k == 6) aclr2 = 1'b1;
         if (k == 7) begin
            check("p2_clr", 64'(r_p2), 64'h0);
            aclr2 = 1'b0; clken2 = 1'b0;
         end
         if (k == 8) check("p2_refill", 64'(r_p2), 64'h0);
         if (k == 9) check("p2_new", 64'(r_p2), 64'd25);
         if (k == 127) check("cnt_127", 64'(r_cnt[14:8]), 64'd127);
         if (k == 128) check("cnt_wrap", 64'(r_cnt[14:8]), 64'd0);
      end

      inc = 1'b0;
      repeat (5) @(negedge clock);
      check("cnt_hold", 64'(r_cnt[14:8]), 64'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
